// File: rtl/if_id_queue_if.sv
// if_id_queue_if: fetch-side and decode-side signals of the IF/ID instruction queue
interface if_id_queue_if #(
    parameter int DEPTH = 4
);
    logic [31:0]                  if_PC;
    logic [31:0]                  if_NPC;
    logic [31:0]                  if_IR;
    logic                         if_valid;
    logic                         flush;
    logic                         id_stall;
    logic                         if_stall;
    logic [31:0]                  id_PC;
    logic [31:0]                  id_NPC;
    logic [31:0]                  id_IR;
    logic                         id_valid;
    logic [$clog2(DEPTH+1)-1:0]   count;

    // Pipeline side: drives fetch data and the decode stall, observes the queue head
    modport master (
        output if_PC, if_NPC, if_IR, if_valid, flush, id_stall,
        input  if_stall, id_PC, id_NPC, id_IR, id_valid, count
    );

    // Queue side
    modport slave (
        input  if_PC, if_NPC, if_IR, if_valid, flush, id_stall,
        output if_stall, id_PC, id_NPC, id_IR, id_valid, count
    );
endinterface

// File: rtl/if_id_queue.sv
// if_id_queue: circular FIFO of {PC, NPC, IR} between fetch and decode; IFQ_BYPASS_EN enables empty-queue bypass
module if_id_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_INST = 32'h47FF041F
) (
    input logic           clk,
    input logic           rst,
    if_id_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [95:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, push, pop, byp, valid;
    logic [95:0]   in_w, head;

    // Handshake decode, next-state pointers/count and head presentation
    always_comb begin
        in_w  = {q.if_PC, q.if_NPC, q.if_IR};
        full  = count_q == CW'(DEPTH);
`ifdef IFQ_BYPASS_EN
        byp   = (count_q == '0) & q.if_valid & ~q.flush;
`else
        byp   = 1'b0;
`endif
        // A bypassed instruction accepted by decode is consumed without being stored
        push  = q.if_valid & ~full & ~q.flush & ~(byp & ~q.id_stall);
        pop   = (count_q != '0) & ~q.id_stall & ~q.flush;
        head  = byp ? in_w : mem_q[rd_ptr_q];
        valid = (count_q != '0) | byp;
        rd_ptr_d = q.flush ? '0 : rd_ptr_q + AW'(pop);
        wr_ptr_d = q.flush ? '0 : wr_ptr_q + AW'(push);
        count_d  = q.flush ? '0 : count_q + CW'(push) - CW'(pop);
        q.if_stall = full;
        q.id_valid = valid;
        q.id_PC    = head[95:64];
        q.id_NPC   = head[63:32];
        q.id_IR    = valid ? head[31:0] : NOP_INST;
        q.count    = count_q;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written so no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_w;
    end
endmodule

// File: tb/tb_if_id_queue.sv
// tb_if_id_queue: randomized and directed checks of if_id_queue against a queue-based reference model
module tb_if_id_queue;
    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h47FF041F;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] ir;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_id_queue_if #(.DEPTH(DEPTH)) bus ();
    if_id_queue #(.DEPTH(DEPTH), .NOP_INST(NOP)) dut (.clk(clk), .rst(rst), .q(bus));

    ent_t        mq[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic        e_valid, e_full, byp_now;
    logic [31:0] e_pc, e_npc, e_ir;
    int          e_cnt;

    function automatic ent_t mk(input logic [31:0] pc);
        return '{pc: pc, npc: pc + 32'd4, ir: pc ^ 32'hDEAD0000};
    endfunction

    // Present inputs, wait for the falling edge and compute expected outputs from the model
    task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic st);
        ent_t in_e, h;
        in_e = mk(pc);
        bus.if_valid = v;
        bus.if_PC    = in_e.pc;
        bus.if_NPC   = in_e.npc;
        bus.if_IR    = in_e.ir;
        bus.flush    = fl;
        bus.id_stall = st;
        @(negedge clk);
        byp_now = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp_now = (mq.size() == 0) && v && !fl;
`endif
        e_cnt   = mq.size();
        e_full  = e_cnt == DEPTH;
        e_valid = (e_cnt != 0) || byp_now;
        h       = byp_now ? in_e : (e_cnt != 0 ? mq[0] : '0);
        e_pc    = h.pc;
        e_npc   = h.npc;
        e_ir    = e_valid ? h.ir : NOP;
    endtask

    // Advance one clock edge and apply the queue rules to the model
    task automatic clock();
        bit full;
        @(posedge clk);
        if (rst || bus.flush) mq.delete();
        else begin
            full = mq.size() == DEPTH;
            if (mq.size() != 0 && !bus.id_stall) void'(mq.pop_front());
            if (bus.if_valid && !full && !(byp_now && !bus.id_stall))
                mq.push_back('{pc: bus.if_PC, npc: bus.if_NPC, ir: bus.if_IR});
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 2 * DEPTH && mq.size() != 0; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            clock();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        clock();
        clock();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b0);
            vectors++;
            if (bus.id_valid !== 1'b0 || bus.id_IR !== NOP || bus.count !== '0 || bus.if_stall !== 1'b0) begin
                miscompares++;
                $display("FAIL reset: valid=%b ir=%h count=%0d if_stall=%b, expected 0 %h 0 0",
                         bus.id_valid, bus.id_IR, bus.count, bus.if_stall, NOP);
            end
            clock();
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 5; i++) begin
            drive(i < 3, 32'(i * 4), 1'b0, 1'b0);
            vectors++;
            if (bus.id_valid !== e_valid || bus.count > 1 ||
                (e_valid && (bus.id_PC !== e_pc || bus.id_NPC !== e_npc || bus.id_IR !== e_ir))) begin
                miscompares++;
                $display("FAIL basic[%0d]: valid=%b pc=%h npc=%h count=%0d, expected %b %h %h <=1",
                         i, bus.id_valid, bus.id_PC, bus.id_NPC, bus.count, e_valid, e_pc, e_npc);
            end
            clock();
        end
    endtask

    task automatic test_full();
        logic pending = 1'b1;
        drain();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h10 + 32'(i * 4), 1'b0, 1'b1);
            clock();
        end
        for (int i = 0; i < 7; i++) begin
            drive(pending, 32'h20, 1'b0, 1'b0);
            vectors++;
            if (bus.count !== e_cnt[$bits(bus.count)-1:0] || bus.if_stall !== e_full ||
                bus.id_valid !== e_valid || (e_valid && bus.id_PC !== e_pc)) begin
                miscompares++;
                $display("FAIL full[%0d]: count=%0d if_stall=%b pc=%h, expected %0d %b %h",
                         i, bus.count, bus.if_stall, bus.id_PC, e_cnt, e_full, e_pc);
            end
            if (i == 0) begin
                vectors++;
                if (bus.if_stall !== 1'b1 || bus.id_PC !== 32'h10 || bus.count !== 3'd4) begin
                    miscompares++;
                    $display("FAIL full_level: if_stall=%b pc=%h count=%0d, expected 1 00000010 4",
                             bus.if_stall, bus.id_PC, bus.count);
                end
            end
            if (!e_full) pending = 1'b0;
            clock();
        end
    endtask

    task automatic test_flush();
        drain();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h30 + 32'(i * 4), 1'b0, 1'b1);
            clock();
        end
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        clock();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++;
        if (bus.count !== '0 || bus.id_valid !== 1'b0 || bus.id_IR !== NOP || bus.if_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL flush: count=%0d valid=%b ir=%h, expected 0 0 %h", bus.count, bus.id_valid, bus.id_IR, NOP);
        end
        clock();
        drive(1'b1, 32'h100, 1'b0, 1'b1);
        clock();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (bus.id_valid !== 1'b1 || bus.id_PC !== 32'h100 || bus.count !== 3'd1) begin
            miscompares++;
            $display("FAIL flush_next: valid=%b pc=%h count=%0d, expected 1 00000100 1", bus.id_valid, bus.id_PC, bus.count);
        end
        clock();
    endtask

    task automatic test_wrap();
        drain();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b1);
            clock();
        end
        for (int i = 2; i < 12; i++) begin
            drive(1'b1, 32'h300 + 32'(i * 4), 1'b0, 1'b0);
            vectors++;
            if (bus.count !== 3'd2 || bus.id_PC !== 32'h300 + 32'((i - 2) * 4) || bus.id_IR !== e_ir) begin
                miscompares++;
                $display("FAIL wrap[%0d]: count=%0d pc=%h ir=%h, expected 2 %h %h",
                         i, bus.count, bus.id_PC, bus.id_IR, 32'h300 + 32'((i - 2) * 4), e_ir);
            end
            clock();
        end
    endtask

    task automatic test_bypass();
        drain();
        drive(1'b1, 32'h200, 1'b0, 1'b0);
        vectors++;
`ifdef IFQ_BYPASS_EN
        if (bus.id_valid !== 1'b1 || bus.id_PC !== 32'h200 || bus.count !== '0) begin
            miscompares++;
            $display("FAIL bypass: valid=%b pc=%h count=%0d, expected 1 00000200 0", bus.id_valid, bus.id_PC, bus.count);
        end
        clock();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (bus.count !== '0 || bus.id_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_consumed: count=%0d valid=%b, expected 0 0", bus.count, bus.id_valid);
        end
`else
        if (bus.id_valid !== 1'b0 || bus.id_IR !== NOP) begin
            miscompares++;
            $display("FAIL latency0: valid=%b ir=%h, expected 0 %h", bus.id_valid, bus.id_IR, NOP);
        end
        clock();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (bus.id_valid !== 1'b1 || bus.id_PC !== 32'h200) begin
            miscompares++;
            $display("FAIL latency1: valid=%b pc=%h, expected 1 00000200", bus.id_valid, bus.id_PC);
        end
`endif
        clock();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom % 97) == 0;
            drive(($urandom % 4) != 0, $urandom & 32'hFFFFFFFC, ($urandom % 20) == 0, ($urandom % 3) == 0);
            vectors++;
            if (bus.count !== e_cnt[$bits(bus.count)-1:0] || bus.if_stall !== e_full ||
                bus.id_valid !== e_valid || bus.id_IR !== e_ir ||
                (e_valid && (bus.id_PC !== e_pc || bus.id_NPC !== e_npc))) begin
                miscompares++;
                $display("FAIL random[%0d]: count=%0d stall=%b valid=%b pc=%h npc=%h ir=%h, expected %0d %b %b %h %h %h",
                         i, bus.count, bus.if_stall, bus.id_valid, bus.id_PC, bus.id_NPC, bus.id_IR,
                         e_cnt, e_full, e_valid, e_pc, e_npc, e_ir);
            end
            clock();
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_flush();
        test_wrap();
        test_bypass();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
